// File: rtl/cdc_handshake_arbiter.sv
// Round-robin arbiter driving the source side of a 4-phase req/ack CDC.
// Ports: clk_i/rst_n_i, req_valid/ready/data, cdc_req/data/src/ack, busy, count.
module cdc_handshake_arbiter #(
  parameter int NB_REQUESTERS = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int NB_REGISTERS  = 2,
  parameter int SRC_W         = $clog2(NB_REQUESTERS)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NB_REQUESTERS-1:0]            req_valid_i,
  input  logic [NB_REQUESTERS*DATA_WIDTH-1:0] req_data_i,
  output logic [NB_REQUESTERS-1:0]            req_ready_o,
  output logic                                cdc_req_o,
  output logic [DATA_WIDTH-1:0]               cdc_data_o,
  output logic [SRC_W-1:0]                    cdc_src_o,
  input  logic                                cdc_ack_i,
  output logic                                busy_o,
  output logic [15:0]                         xfer_count_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_HIGH,
    REQ_LOW
  } state_e;

  state_e                  state_q, state_d;
  logic [NB_REGISTERS-1:0] ack_sync_q, ack_sync_d;
  logic [SRC_W-1:0]        last_grant_q, last_grant_d;
  logic                    cdc_req_q, cdc_req_d;
  logic [DATA_WIDTH-1:0]   cdc_data_q, cdc_data_d;
  logic [SRC_W-1:0]        cdc_src_q, cdc_src_d;
  logic [15:0]             xfer_count_q, xfer_count_d;

  logic                    ack_sync;
  logic                    win_found;
  logic [SRC_W-1:0]        win_idx;
  logic [SRC_W-1:0]        cand;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    accept;

  // Raw ack enters only through the synchronizer chain.
  assign ack_sync_d = {ack_sync_q[NB_REGISTERS-2:0], cdc_ack_i};
  assign ack_sync   = ack_sync_q[NB_REGISTERS-1];

  // Search upward from the requester after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NB_REQUESTERS; k++) begin
      cand = SRC_W'((int'(last_grant_q) + k) % NB_REQUESTERS);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NB_REQUESTERS; i++) begin
      if (win_idx == SRC_W'(i)) begin
        win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gated by reset so no strobe leaks out while held in reset.
  assign accept = rst_n_i && (state_q == IDLE) &&
                  !ack_sync && win_found;

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cdc_req_d    = cdc_req_q;
    cdc_data_d   = cdc_data_q;
    cdc_src_d    = cdc_src_q;
    xfer_count_d = xfer_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cdc_data_d   = win_data;
          cdc_src_d    = win_idx;
          last_grant_d = win_idx;
          cdc_req_d    = 1'b1;
          state_d      = REQ_HIGH;
        end
      end
      REQ_HIGH: begin
        if (ack_sync) begin
          cdc_req_d = 1'b0;
          state_d   = REQ_LOW;
        end
      end
      REQ_LOW: begin
        if (!ack_sync) begin
          state_d      = IDLE;
          xfer_count_d = xfer_count_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        cdc_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      ack_sync_q   <= '0;
      last_grant_q <= SRC_W'(NB_REQUESTERS - 1);
      cdc_req_q    <= 1'b0;
      cdc_data_q   <= '0;
      cdc_src_q    <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ack_sync_q   <= ack_sync_d;
      last_grant_q <= last_grant_d;
      cdc_req_q    <= cdc_req_d;
      cdc_data_q   <= cdc_data_d;
      cdc_src_q    <= cdc_src_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign cdc_req_o    = cdc_req_q;
  assign cdc_data_o   = cdc_data_q;
  assign cdc_src_o    = cdc_src_q;
  assign busy_o       = (state_q != IDLE);
  assign xfer_count_o = xfer_count_q;

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Bench for cdc_handshake_arbiter: vector table, ack model, scoreboard.
// Drives at negedge+1, monitors at posedge+1, ack model at negedge.
module tb_cdc_handshake_arbiter;

  localparam int NBR  = 4;
  localparam int DW   = 32;
  localparam int NREG = 2;

  logic            clk;
  logic            rst_n;
  logic [NBR-1:0]  req_valid;
  logic [NBR*DW-1:0] req_data;
  logic [NBR-1:0]  req_ready_o;
  logic            cdc_req_o;
  logic [DW-1:0]   cdc_data_o;
  logic [1:0]      cdc_src_o;
  logic            cdc_ack;
  logic            busy_o;
  logic [15:0]     xfer_count_o;

  logic ack_auto;
  logic ack_force;
  logic ack_model;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];

  function automatic logic [31:0] data_of(input logic [1:0] i);
    case (i)
      2'd0:    data_of = 32'h0123_4567;
      2'd1:    data_of = 32'h89AB_CDEF;
      2'd2:    data_of = 32'hDEAD_BEEF;
      default: data_of = 32'hCAFE_F00D;
    endcase
  endfunction

  assign req_data = {data_of(2'd3), data_of(2'd2),
                     data_of(2'd1), data_of(2'd0)};
  assign cdc_ack  = ack_auto ? ack_model : ack_force;

  cdc_handshake_arbiter #(
    .NB_REQUESTERS(NBR),
    .DATA_WIDTH(DW),
    .NB_REGISTERS(NREG)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_ready_o(req_ready_o),
    .cdc_req_o(cdc_req_o),
    .cdc_data_o(cdc_data_o),
    .cdc_src_o(cdc_src_o),
    .cdc_ack_i(cdc_ack),
    .busy_o(busy_o),
    .xfer_count_o(xfer_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_count(input string name,
                            input logic [15:0] target);
    int n;
    n = 0;
    while (xfer_count_o !== target && n < 2000) begin
      tick();
      n++;
    end
    chk(name, {16'd0, xfer_count_o}, {16'd0, target});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Ack model: follows cdc_req_o after three cycles of mismatch.
  initial begin
    int acnt;
    acnt      = 0;
    ack_model = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_auto && cdc_req_o !== ack_model) begin
        acnt++;
        if (acnt == 3) begin
          ack_model = cdc_req_o;
          acnt      = 0;
        end
      end else begin
        acnt = 0;
      end
    end
  end

  // Monitor: ready legality and scoreboard pops on request rise.
  initial begin
    logic       prev_req;
    logic [1:0] cur;
    prev_req = 1'b0;
    cur      = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      if (req_ready_o != '0) begin
        chk("ready_onehot", $countones(req_ready_o), 1);
        chk("ready_in_valid", {28'd0, req_ready_o & ~req_valid}, 0);
      end
      if (cdc_req_o && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: src %0d with empty queue",
                   cdc_src_o);
        end else begin
          cur = exp_q.pop_front();
          chk("sb_src", {30'd0, cdc_src_o}, {30'd0, cur});
          chk("sb_data", cdc_data_o, data_of(cur));
        end
      end
      if (!cdc_req_o && prev_req && rst_n) begin
        chk("hold_src", {30'd0, cdc_src_o}, {30'd0, cur});
        chk("hold_data", cdc_data_o, data_of(cur));
      end
      prev_req = cdc_req_o;
    end
  end

  typedef struct {
    logic [3:0] mask;
    logic [1:0] src;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    logic [15:0] c0;
    logic [3:0]  onehot;

    vecs[0] = '{4'b0100, 2'd2};
    vecs[1] = '{4'b1111, 2'd3};
    vecs[2] = '{4'b1111, 2'd0};
    vecs[3] = '{4'b1010, 2'd1};
    vecs[4] = '{4'b1010, 2'd3};
    vecs[5] = '{4'b0001, 2'd0};
    vecs[6] = '{4'b1001, 2'd3};
    vecs[7] = '{4'b1001, 2'd0};
    vecs[8] = '{4'b0110, 2'd1};
    vecs[9] = '{4'b0110, 2'd2};

    ack_auto  = 1'b1;
    ack_force = 1'b0;
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    repeat (2) tick();
    chk("rst_ready", {28'd0, req_ready_o}, 0);
    chk("rst_req", {31'd0, cdc_req_o}, 0);
    chk("rst_data", cdc_data_o, 0);
    chk("rst_src", {30'd0, cdc_src_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_count", {16'd0, xfer_count_o}, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].src);
      c0        = xfer_count_o;
      req_valid = vecs[i].mask;
      #1;
      n = 0;
      while (req_ready_o == '0 && n < 50) begin
        tick();
        n++;
      end
      onehot = 4'b0001 << vecs[i].src;
      chk("vec_ready", {28'd0, req_ready_o}, {28'd0, onehot});
      wait_count("vec_count", c0 + 16'd1);
      req_valid = '0;
      chk("vec_busy_low", {31'd0, busy_o}, 0);
    end
    chk("table_count", {16'd0, xfer_count_o}, 10);

    do_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    req_valid = 4'b1111;
    wait_count("rr_count", 16'd8);
    req_valid = '0;
    chk("rr_queue_empty", exp_q.size(), 0);

    exp_q = {2'd1, 2'd3, 2'd1, 2'd3};
    req_valid = 4'b1010;
    wait_count("skip_count", 16'd12);
    req_valid = '0;
    chk("skip_queue_empty", exp_q.size(), 0);

    exp_q.push_back(2'd1);
    req_valid = 4'b0010;
    n = 0;
    while (!cdc_req_o && n < 50) begin
      tick();
      n++;
    end
    chk("mid_req_seen", {31'd0, cdc_req_o}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_req_async", {31'd0, cdc_req_o}, 0);
    chk("mid_busy_async", {31'd0, busy_o}, 0);
    chk("mid_count_async", {16'd0, xfer_count_o}, 0);
    req_valid = 4'b1111;
    repeat (2) tick();
    chk("mid_ready_in_rst", {28'd0, req_ready_o}, 0);
    exp_q.push_back(2'd0);
    rst_n = 1'b1;
    wait_count("mid_after_count", 16'd1);
    req_valid = '0;
    chk("mid_queue_empty", exp_q.size(), 0);

    ack_auto  = 1'b0;
    ack_force = 1'b1;
    do_reset();
    repeat (3) tick();
    req_valid = 4'b0001;
    n = 0;
    repeat (10) begin
      tick();
      if (req_ready_o != '0 || cdc_req_o) n++;
    end
    chk("stale_blocked", n, 0);
    exp_q.push_back(2'd0);
    ack_force = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready_o == '0 && n < 20);
    chk("stale_release_lat", n, NREG);
    ack_auto = 1'b1;
    wait_count("stale_count", 16'd1);
    req_valid = '0;

    force dut.xfer_count_q = 16'hFFFE;
    #1;
    release dut.xfer_count_q;
    exp_q = {2'd0, 2'd0};
    req_valid = 4'b0001;
    wait_count("wrap_count", 16'd0);
    req_valid = '0;
    chk("wrap_busy_low", {31'd0, busy_o}, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_arbiter.md
# cdc_handshake_arbiter

Source-side controller for a 4-phase req/ack clock-domain crossing. It arbitrates round-robin between NB_REQUESTERS local requesters and captures the winner's word into a held data register. It drives a single-bit request across the crossing and synchronizes the returning acknowledge internally with an NB_REGISTERS flip-flop chain. It sits in the source clock domain in front of the destination-side request synchronizer and data capture logic.

## Interface
- NB_REQUESTERS, default 4: number of requesters (≥2).
- DATA_WIDTH, default 32: width of each transferred word.
- NB_REGISTERS, default 2: depth of the internal ack synchronizer chain (≥2).
- SRC_W, default $clog2(NB_REQUESTERS): width of the source id.
- clk_i  in  1  source-domain clock.
- rst_n_i  in  1  asynchronous active-low reset; deassertion is synchronous to clk_i externally.
- req_valid_i  in  NB_REQUESTERS  per-requester valid, held until accepted.
- req_data_i  in  NB_REQUESTERS*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  out  NB_REQUESTERS  one-hot accept strobe; transfer occurs on the edge where valid&ready.
- cdc_req_o  out  1  registered request to the destination domain.
- cdc_data_o  out  DATA_WIDTH  registered held data, stable while cdc_req_o or the ack is active.
- cdc_src_o  out  SRC_W  id of the requester owning cdc_data_o.
- cdc_ack_i  in  1  raw acknowledge from the destination domain, asynchronous to clk_i.
- busy_o  out  1  high whenever the state is not IDLE.
- xfer_count_o  out  16  count of completed transfers, wraps modulo 2^16.

## Operation
- FSM states: IDLE, REQ_HIGH, REQ_LOW.
- ack_sync is the output of NB_REGISTERS flops clocked by clk_i that sample cdc_ack_i. All flops reset to 0. Only ack_sync is used; cdc_ack_i never drives logic directly.
- Arbitration in IDLE:
  - The winner is the first requester with valid=1, searching upward from last_grant+1 modulo NB_REQUESTERS.
  - req_ready_o[winner] = 1 combinationally only when state==IDLE and ack_sync==0.
  - All other bits of req_ready_o are 0.
- Accept edge:
  - cdc_data_o ← winner's data.
  - cdc_src_o ← winner.
  - last_grant ← winner.
  - cdc_req_o ← 1.
  - state ← REQ_HIGH.
- REQ_HIGH: hold all outputs. When ack_sync==1, at the next edge cdc_req_o ← 0 and state ← REQ_LOW.
- REQ_LOW: hold data. When ack_sync==0, at the next edge state ← IDLE and xfer_count_o increments.
- cdc_data_o and cdc_src_o change only on an accept edge. Between transfers they keep their last value.
- Stale ack: if ack_sync==1 while in IDLE (destination left asserted after a source reset), no accept occurs until ack_sync returns to 0.
- Simultaneous valids: exactly one is granted per transfer. A continuously asserted requester is served at least once every NB_REQUESTERS transfers.
- Deasserting a valid before acceptance is a protocol violation. Behaviour is defined only in that the grant is recomputed each IDLE cycle.
- Reset values:
  - state = IDLE.
  - cdc_req_o = 0, cdc_data_o = 0, cdc_src_o = 0.
  - busy_o = 0, xfer_count_o = 0.
  - req_ready_o = 0 while in reset.
  - last_grant = NB_REQUESTERS-1, so requester 0 has first priority.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous). cdc_req_o drops, and the destination sees an aborted request. The stale-ack rule prevents a new transfer from starting before the old ack clears.

## Timing
- Accept at edge T. cdc_req_o, cdc_data_o and cdc_src_o are valid after T. busy_o is high after T.
- A raw ack rising before edge A is seen in ack_sync after edge A+NB_REGISTERS-1. cdc_req_o falls one edge later.
- The falling ack is handled symmetrically. IDLE is entered on the edge where the state leaves REQ_LOW, and the next accept can occur in the same cycle IDLE is entered.
- Minimum cycles per transfer = 3 + 2*NB_REGISTERS, plus destination-side latency.
- req_ready_o is combinational from state, ack_sync, last_grant and req_valid_i. All other outputs are registered.

## Test plan
- Single transfer:
  - Stimulus: NB_REQUESTERS=4, NB_REGISTERS=2. Requester 2 valid with data 0xDEADBEEF. Bench ack model raises ack 3 cycles after cdc_req_o and lowers it 3 cycles after cdc_req_o falls.
  - Required response: req_ready_o=4'b0100 for one cycle. cdc_data_o=0xDEADBEEF and cdc_src_o=2 held throughout. xfer_count_o goes 0→1. busy_o is low afterwards.
- Round-robin:
  - Stimulus: all four valids held high for 8 transfers.
  - Required response: grant order 0,1,2,3,0,1,2,3. xfer_count_o=8.
- Skip idle requesters:
  - Stimulus: only requesters 1 and 3 valid.
  - Required response: grant order 1,3,1,3. req_ready_o never targets 0 or 2.
- Stale ack:
  - Stimulus: cdc_ack_i held at 1 out of reset while requester 0 is valid.
  - Required response: no req_ready_o and cdc_req_o=0. After ack drops, the accept occurs NB_REGISTERS cycles later.
- Reset mid-transfer:
  - Stimulus: assert rst_n_i=0 while in REQ_HIGH.
  - Required response: cdc_req_o, busy_o and xfer_count_o read 0 without waiting for a clock edge. After release with the ack low, requester 0 wins first.
- Wrap:
  - Stimulus: preload by running 65536 transfers.
  - Required response: xfer_count_o wraps to 0.
